// File: rtl/fifo_pkg.sv
// Shared sizing for the fifo_queue slice: default word width, depth and the
// pointer-width helper used by the queue and its pointer counters.
package fifo_pkg;

   localparam int FIFO_WIDTH = 8;
   localparam int FIFO_DEPTH = 8;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   localparam int FIFO_PTR_W = ptr_w(FIFO_DEPTH);

endpackage

// File: rtl/fifo_queue_if.sv
// Request/status bundle between a fifo_queue and its user.
// The master drives enable/requests/data; the slave (the queue) drives status.
interface fifo_queue_if
   import fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH,
   parameter int DEPTH = FIFO_DEPTH
);
   logic                       enable;
   logic                       wr_en;
   logic                       rd_en;
   logic [WIDTH-1:0]           data_in;
   logic [WIDTH-1:0]           data_out;
   logic                       fifo_empty;
   logic                       fifo_full;
   logic [ptr_w(DEPTH):0]      count;
   logic                       overflow;
   logic                       underflow;

   modport master (
      output enable, wr_en, rd_en, data_in,
      input  data_out, fifo_empty, fifo_full, count, overflow, underflow
   );

   modport slave (
      input  enable, wr_en, rd_en, data_in,
      output data_out, fifo_empty, fifo_full, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_ptr.sv
// Purpose: wrapping pointer counter for the queue's read and write sides.
// Latency: ptr advances on the clk edge where inc is high.
// Backpressure: none; the caller qualifies inc.
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      inc,
   output logic [ptr_w(DEPTH)-1:0]   ptr
);
   localparam int PW = ptr_w(DEPTH);

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (inc) begin
         if (ptr == PW'(DEPTH - 1)) ptr <= '0;
         else                       ptr <= ptr + 1'b1;
      end
   end
endmodule

// File: rtl/fifo_queue.sv
// Purpose: synchronous first-word-fall-through FIFO with sticky error flags.
// Latency: a write into an empty queue shows on data_out the next cycle.
// Backpressure: full rejects writes unless a read happens the same cycle.
module fifo_queue
   import fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   fifo_queue_if.slave   bus
);
   localparam int PTR_W = ptr_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             overflow;
   logic             underflow;
   logic             fifo_empty;
   logic             fifo_full;
   logic             rd_ok;
   logic             wr_ok;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == (PTR_W+1)'(DEPTH));

   // a full queue may still take a write when the head leaves this cycle
   assign rd_ok = bus.enable & bus.rd_en & ~fifo_empty;
   assign wr_ok = bus.enable & bus.wr_en & (~fifo_full | rd_ok);

   fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (wr_ok),
      .ptr   (wr_ptr)
   );

   fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (rd_ok),
      .ptr   (rd_ptr)
   );

   // storage is not reset; stale words are hidden by the empty mask below
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= bus.data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (bus.enable & bus.wr_en & ~wr_ok)   overflow  <= 1'b1;
         if (bus.enable & bus.rd_en & fifo_empty) underflow <= 1'b1;
      end
   end

   assign bus.data_out   = fifo_empty ? '0 : mem[rd_ptr];
   assign bus.fifo_empty = fifo_empty;
   assign bus.fifo_full  = fifo_full;
   assign bus.count      = count;
   assign bus.overflow   = overflow;
   assign bus.underflow  = underflow;
endmodule

// File: tb/tb_fifo_queue.sv
// Directed bench for fifo_queue: fill/overflow, full read+write, underflow,
// enable gating, a wrapping stream against a queue model, and reset mid-traffic.
module tb_fifo_queue;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   fifo_queue_if #(.WIDTH(8), .DEPTH(8)) bus ();

   fifo_queue #(.WIDTH(8), .DEPTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic drive(input logic en, input logic wr, input logic rd, input logic [7:0] d);
      bus.enable  = en;
      bus.wr_en   = wr;
      bus.rd_en   = rd;
      bus.data_in = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_q [$];
   logic [7:0] wd;
   logic       w, r;
   int         sent, got, mc;

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      reset = 1'b0;
      chk("rst_count", bus.count, 0);
      chk("rst_empty", bus.fifo_empty, 1);
      chk("rst_full", bus.fifo_full, 0);
      chk("rst_ovf", bus.overflow, 0);
      chk("rst_udf", bus.underflow, 0);
      chk("rst_dout", bus.data_out, 8'h00);

      // fill with 11..88
      for (int i = 1; i <= 8; i++) begin
         wd = 8'(i * 8'h11);
         drive(1'b1, 1'b1, 1'b0, wd);
         tick();
         if (i == 1) begin
            chk("first_dout", bus.data_out, 8'h11);
            chk("first_count", bus.count, 1);
         end
      end
      chk("fill_full", bus.fifo_full, 1);
      chk("fill_count", bus.count, 8);
      chk("fill_dout", bus.data_out, 8'h11);
      chk("fill_ovf", bus.overflow, 0);

      drive(1'b1, 1'b1, 1'b0, 8'h99);
      tick();
      chk("ovf_set", bus.overflow, 1);
      chk("ovf_count", bus.count, 8);
      chk("ovf_dout", bus.data_out, 8'h11);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      chk("ovf_sticky", bus.overflow, 1);

      drive(1'b1, 1'b1, 1'b1, 8'hAA);
      tick();
      chk("fullrw_dout", bus.data_out, 8'h22);
      chk("fullrw_count", bus.count, 8);

      // drain: 22..88 then AA
      for (int i = 2; i <= 9; i++) begin
         wd = (i == 9) ? 8'hAA : 8'(i * 8'h11);
         chk("drain_dout", bus.data_out, wd);
         drive(1'b1, 1'b0, 1'b1, 8'h00);
         tick();
      end
      chk("drain_empty", bus.fifo_empty, 1);
      chk("drain_dout0", bus.data_out, 8'h00);

      drive(1'b0, 1'b1, 1'b1, 8'h77);
      tick();
      chk("dis_count", bus.count, 0);
      chk("dis_udf", bus.underflow, 0);

      drive(1'b1, 1'b0, 1'b1, 8'h00);
      tick();
      chk("udf_set", bus.underflow, 1);
      chk("udf_count", bus.count, 0);
      chk("udf_dout", bus.data_out, 8'h00);

      drive(1'b1, 1'b1, 1'b1, 8'h5A);
      tick();
      chk("emptyrw_count", bus.count, 1);
      chk("emptyrw_dout", bus.data_out, 8'h5A);
      chk("udf_sticky", bus.underflow, 1);

      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      reset = 1'b0;
      chk("rst2_count", bus.count, 0);

      // stream of 20 words with random request gaps
      sent = 0; got = 0; mc = 0;
      for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
         w  = (sent < 20) && (mc < 8) && ($urandom_range(0, 1) == 1);
         r  = (mc > 0) && ($urandom_range(0, 1) == 1);
         wd = 8'(8'h30 + sent);
         if (r) begin
            chk("stream_order", bus.data_out, exp_q[0]);
            void'(exp_q.pop_front());
            got++;
            mc--;
         end
         if (w) begin
            exp_q.push_back(wd);
            sent++;
            mc++;
         end
         drive(1'b1, w, r, wd);
         tick();
         chk("stream_count", bus.count, mc);
      end
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      chk("stream_done", got, 20);
      chk("stream_ovf", bus.overflow, 0);
      chk("stream_udf", bus.underflow, 0);

      drive(1'b1, 1'b0, 1'b1, 8'h00);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
         tick();
      end
      chk("pre_rst_count", bus.count, 5);
      chk("pre_rst_udf", bus.underflow, 1);
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 8'hEE);
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      chk("midrst_count", bus.count, 0);
      chk("midrst_empty", bus.fifo_empty, 1);
      chk("midrst_ovf", bus.overflow, 0);
      chk("midrst_udf", bus.underflow, 0);
      chk("midrst_dout", bus.data_out, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
